cache_bus_axi_bridge: RTL and testbench
=======================================

# cache_bus_axi_bridge

Converts the LSU data cache's memory-bus transactions (line refills, dirty-line writebacks, uncached single accesses) into AXI4 master transactions. Sits directly downstream of `lsu`: its cache-side ports carry the fields of `cache_bus_req_t`/`cache_bus_resp_t`, and its AXI side connects to the SoC interconnect. One transaction is outstanding at a time. Read data streams back to the refill state machine beat by beat.

## Interface
- `LINE_WORDS`, default 4: words per cache line. Power of two, 1–16; 4 matches CACHE_SHIFT=12.
- `AXI_ID`, default 1: constant ARID/AWID value.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `breq_i` in `cache_bus_req_t`: cache-side request channel.
  - `valid`, `write`, `uncached`, `addr[31:0]`, `size[1:0]`, `strb[3:0]`: request.
  - `wvalid`, `wdata[31:0]`: write-data stream.
- `bresp_o` out `cache_bus_resp_t`: cache-side response channel.
  - `ready`: request accept.
  - `wready`: write-data accept.
  - `rvalid`, `rdata[31:0]`, `rlast`: read-data stream.
  - `wdone`: write complete.
  - `err`: bus error.
- AXI AR: `arvalid/arready/araddr[31:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]/arid[3:0]`.
- AXI R: `rvalid/rready/rdata[31:0]/rresp[1:0]/rlast`.
- AXI AW: `awvalid/awready/awaddr/awlen/awsize/awburst/awid`, same widths as AR.
- AXI W: `wvalid/wready/wdata[31:0]/wstrb[3:0]/wlast`.
- AXI B: `bvalid/bready/bresp[1:0]`.

## Operation
- FSM states: S_IDLE, S_AR, S_R, S_AW, S_W, S_B.
- S_IDLE:
  - `ready`=1 only in this state.
  - On `valid`, latch the request and go to S_AW if `write`, else S_AR.
- Cached request:
  - Address is line-aligned: low `log2(LINE_WORDS)+2` bits forced to 0.
  - len=LINE_WORDS-1, size=2, burst=INCR, wstrb=4'hF.
- Uncached request:
  - addr as given, len=0, burst=INCR.
  - size = `size` (0 byte, 1 half, 2 word).
  - wstrb = latched `strb`.
- S_AR: `arvalid`=1 until `arready`, then S_R.
- S_R:
  - `rready`=1. The cache never back-pressures reads.
  - `rvalid`/`rdata`/`rlast` pass through combinationally; `rlast` comes from AXI rlast.
  - A beat counter counts beats. `err` pulses with the last beat if any beat had rresp≠0, or if AXI rlast arrives on a beat count ≠ len+1.
  - After the rlast handshake, go to S_IDLE.
- S_AW: `awvalid`=1 until `awready`, then S_W. No W beat is issued before AW is accepted.
- S_W:
  - AXI `wvalid`=`breq_i.wvalid`, `wdata` passes through, `bresp_o.wready`=AXI `wready`.
  - `wlast` is asserted when the beat counter equals len.
  - After the last beat handshake, go to S_B.
- S_B:
  - `bready`=1.
  - On `bvalid`, pulse `wdone` (and `err` if bresp≠0) for one cycle, then S_IDLE.
- Beat counter: `$clog2(LINE_WORDS)+1` bits. Cleared on request accept; increments per handshaken beat. It never wraps within a legal burst.
- A new request can be accepted the cycle after return to S_IDLE; there are no back-to-back accepts in the same cycle.

## Timing
- Reset values: state S_IDLE; all AXI valids and readies 0; `ready`=0 during reset; `rvalid`, `rlast`, `wready`, `wdone`, `err` = 0; address/len registers 0.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous). The AXI transaction is abandoned; the system resets the interconnect together with the bridge.
- Read: accept in cycle N; `arvalid` high from N+1. The first `rvalid` can reach the cache in the same cycle as AXI rvalid (0-cycle pass-through).
- Write: accept in N; `awvalid` from N+1. W beats can start the cycle after the `awready` handshake. `wdone` comes one cycle after the `bvalid` sample at the earliest, registered.
- AXI AR/AW payloads are registered and stable while valid is high.
- `err` is a one-cycle pulse, never sticky.

## Structure
- Shared package `lsu_pkg`:
  - `cache_bus_req_t`, `cache_bus_resp_t`.
  - AXI burst/size/resp constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - State enum type.
- No sub-modules. The FSM, beat counter and payload registers all live in one module.

## Test plan
- Cached read, LINE_WORDS=4, addr 0x0000_1234:
  - araddr=0x0000_1230, arlen=3, arsize=2.
  - 4 beats 0xA0..0xA3 are forwarded in order; `rlast` is on the 4th beat; `err`=0.
- Uncached byte read, addr 0x1FE0_0003, size 0: araddr=0x1FE0_0003, arlen=0, arsize=0, single beat with `rlast`=1.
- Cached writeback with `breq_i.wvalid` gaps and `awready` delayed 5 cycles:
  - No W beat is issued before the AW handshake.
  - 4 beats with wstrb=F; `wlast` only on beat 4; `wdone` pulses once.
- Uncached store with strb=4'b0100: wstrb=0100, wlast=1, awlen=0; bresp=SLVERR → `wdone` and `err` pulse together.
- Read returning AXI rlast on beat 2 of a 4-beat burst: `err` pulses, FSM returns to S_IDLE, and the next request is accepted.
- `rst_n` dropped during beat 2 of a refill: all valids drop immediately; after release `ready`=1 and a fresh read completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the LSU memory-bus side and the
// AXI4 bridge that serves it.
//   cache_bus_req_t  : cache -> bridge request and write-data stream
//   cache_bus_resp_t : bridge -> cache accept, read-data stream, completion
//   bridge_state_t   : bridge FSM state encoding
package lsu_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic        uncached;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic        wvalid;
        logic [31:0] wdata;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        wready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
        logic        wdone;
        logic        err;
    } cache_bus_resp_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } bridge_state_t;

    // Clear the byte-offset-within-line bits of an address.
    function automatic logic [31:0] line_align(input logic [31:0] a, input int off_bits);
        return a & ~((32'd1 << off_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_bus_axi_bridge.sv
// cache_bus_axi_bridge: turns data-cache bus transactions (line refills,
// dirty-line writebacks, uncached single accesses) into AXI4 master bursts.
// One transaction in flight at a time.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   breq_i / bresp_o  : cache-side request / response structs
//   ar*, r*           : AXI read address / read data channels
//   aw*, w*, b*       : AXI write address / write data / write response
//   fsm_state         : current FSM state, for observation only
//
// Handshakes: every channel transfers on a cycle where its valid and ready
// are both high at the rising clock edge; a valid, once raised, holds its
// payload stable until that transfer happens.
module cache_bus_axi_bridge
    import lsu_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int AXI_ID     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  cache_bus_req_t  breq_i,
    output cache_bus_resp_t bresp_o,
    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [3:0]      arid,
    input  logic            rvalid,
    output logic            rready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [3:0]      awid,
    output logic            wvalid,
    input  logic            wready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp,
    output bridge_state_t   fsm_state
);

    localparam int CW  = $clog2(LINE_WORDS) + 1;
    localparam int OFF = $clog2(LINE_WORDS) + 2;

    bridge_state_t state;
    logic          ready_q;
    logic          arvalid_q, awvalid_q, rready_q, bready_q;
    logic          wdone_q, berr_q;
    logic          rd_err_q;       // earlier beat of this burst was bad
    logic [31:0]   ax_addr;
    logic [7:0]    ax_len;
    logic [2:0]    ax_size;
    logic [3:0]    ax_strb;
    logic [CW-1:0] cnt;

    logic at_last;
    logic r_beat, w_beat;
    logic rd_err;

    assign at_last = (8'(cnt) == ax_len);
    assign r_beat  = (state == S_R) && rvalid;
    assign w_beat  = (state == S_W) && breq_i.wvalid && wready;
    // Read error reported alongside the final beat: a bad response anywhere
    // in the burst, or rlast arriving on the wrong beat count.
    assign rd_err  = r_beat && rlast && (rd_err_q || (rresp != RESP_OKAY) || !at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            wdone_q   <= 1'b0;
            berr_q    <= 1'b0;
            rd_err_q  <= 1'b0;
            ax_addr   <= '0;
            ax_len    <= '0;
            ax_size   <= '0;
            ax_strb   <= '0;
            cnt       <= '0;
        end else begin
            wdone_q <= 1'b0;
            berr_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ready_q && breq_i.valid) begin
                        ready_q  <= 1'b0;
                        cnt      <= '0;
                        rd_err_q <= 1'b0;
                        if (breq_i.uncached) begin
                            ax_addr <= breq_i.addr;
                            ax_len  <= 8'd0;
                            ax_size <= {1'b0, breq_i.size};
                            ax_strb <= breq_i.strb;
                        end else begin
                            ax_addr <= line_align(breq_i.addr, OFF);
                            ax_len  <= 8'(LINE_WORDS - 1);
                            ax_size <= 3'd2;
                            ax_strb <= 4'hF;
                        end
                        if (breq_i.write) begin
                            state     <= S_AW;
                            awvalid_q <= 1'b1;
                        end else begin
                            state     <= S_AR;
                            arvalid_q <= 1'b1;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (r_beat) begin
                        cnt <= cnt + CW'(1);
                        // Extra beats past len also count as a length error.
                        if (rresp != RESP_OKAY || (!rlast && at_last))
                            rd_err_q <= 1'b1;
                        if (rlast) begin
                            rready_q <= 1'b0;
                            ready_q  <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (w_beat) begin
                        cnt <= cnt + CW'(1);
                        if (at_last) begin
                            bready_q <= 1'b1;
                            state    <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        wdone_q  <= 1'b1;
                        berr_q   <= (bresp != RESP_OKAY);
                        ready_q  <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    assign arvalid = arvalid_q;
    assign araddr  = ax_addr;
    assign arlen   = ax_len;
    assign arsize  = ax_size;
    assign arburst = BURST_INCR;
    assign arid    = 4'(AXI_ID);
    assign rready  = rready_q;

    assign awvalid = awvalid_q;
    assign awaddr  = ax_addr;
    assign awlen   = ax_len;
    assign awsize  = ax_size;
    assign awburst = BURST_INCR;
    assign awid    = 4'(AXI_ID);

    // W is gated by state so no beat can leave before AW has been accepted.
    assign wvalid  = (state == S_W) && breq_i.wvalid;
    assign wdata   = breq_i.wdata;
    assign wstrb   = ax_strb;
    assign wlast   = (state == S_W) && at_last;
    assign bready  = bready_q;

    always_comb begin
        bresp_o        = '0;
        bresp_o.ready  = ready_q;
        bresp_o.wready = (state == S_W) && wready;
        bresp_o.rvalid = r_beat;
        bresp_o.rdata  = rdata;
        bresp_o.rlast  = r_beat && rlast;
        bresp_o.wdone  = wdone_q;
        bresp_o.err    = berr_q || rd_err;
    end

endmodule

// File: tb/tb_cache_bus_axi_bridge.sv
module tb_cache_bus_axi_bridge;
    import lsu_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    cache_bus_req_t  breq;
    cache_bus_resp_t bresp_c;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [31:0]     araddr, rdata, awaddr, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic [3:0]      arid, awid, wstrb;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    bridge_state_t   fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    cache_bus_axi_bridge #(.LINE_WORDS(4), .AXI_ID(1)) dut (
        .clk(clk), .rst_n(rst_n), .breq_i(breq), .bresp_o(bresp_c),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .fsm_state(fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drivers: all driving happens at the falling edge.
    task automatic issue_req(input string tag, input logic wr, input logic unc,
                             input logic [31:0] addr, input logic [1:0] size,
                             input logic [3:0] strb);
        bit seen = 0;
        breq.valid    = 1'b1;
        breq.write    = wr;
        breq.uncached = unc;
        breq.addr     = addr;
        breq.size     = size;
        breq.strb     = strb;
        for (int k = 0; k < 20; k++) begin
            if (bresp_c.ready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        breq.valid = 1'b0;
    endtask

    // Full read: request, AR checks, nbeats R beats with rlast on the last one.
    task automatic read_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic unc, input logic [31:0] exp_addr, input logic [7:0] exp_len,
                            input logic [2:0] exp_size, input int nbeats,
                            input logic [31:0] dbase, input logic exp_err);
        issue_req(tag, 1'b0, unc, addr, size, 4'h0);
        check({tag, "_arvalid"}, 32'(arvalid), 32'd1);
        check({tag, "_araddr"}, araddr, exp_addr);
        check({tag, "_arlen"}, 32'(arlen), 32'(exp_len));
        check({tag, "_arsize"}, 32'(arsize), 32'(exp_size));
        check({tag, "_arburst_id"}, {24'd0, arburst, 2'd0, arid}, {24'd0, 2'b01, 2'd0, 4'd1});
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check({tag, "_rready"}, {31'd0, rready}, 32'd1);
        for (int i = 0; i < nbeats; i++) exp_q.push_back(dbase + 32'(i));
        for (int i = 0; i < nbeats; i++) begin
            rvalid = 1'b1;
            rdata  = dbase + 32'(i);
            rresp  = RESP_OKAY;
            rlast  = (i == nbeats - 1);
            #1;
            check({tag, "_rvalid"}, 32'(bresp_c.rvalid), 32'd1);
            check({tag, "_rdata"}, bresp_c.rdata, exp_q.pop_front());
            check({tag, "_rlast"}, 32'(bresp_c.rlast), 32'(i == nbeats - 1));
            check({tag, "_err"}, 32'(bresp_c.err), (i == nbeats - 1) ? 32'(exp_err) : 32'd0);
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        check({tag, "_idle"}, 32'(fsm_state), 32'(S_IDLE));
        check({tag, "_ready_again"}, 32'(bresp_c.ready), 32'd1);
    endtask

    int beat;
    bit wpat[6] = '{1, 0, 1, 1, 0, 1};

    initial begin
        breq    = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;

        // Reset state
        #12;
        check("rst_ready", 32'(bresp_c.ready), 32'd0);
        check("rst_valids", {28'd0, arvalid, awvalid, wvalid, bresp_c.rvalid}, 32'd0);
        check("rst_readies", {30'd0, rready, bready}, 32'd0);
        check("rst_addr_len", araddr | 32'(arlen), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bresp_c.ready), 32'd1);

        // Cached refill, line-aligned
        read_txn("c_rd", 32'h0000_1234, 2'd2, 1'b0, 32'h0000_1230, 8'd3, 3'd2, 4, 32'hA0, 1'b0);

        // Uncached byte read
        read_txn("u_rd", 32'h1FE0_0003, 2'd0, 1'b1, 32'h1FE0_0003, 8'd0, 3'd0, 1, 32'h55, 1'b0);

        // Cached writeback, awready held off 5 cycles, wvalid gaps
        issue_req("c_wr", 1'b1, 1'b0, 32'h0000_2048, 2'd2, 4'h0);
        check("c_wr_awvalid", 32'(awvalid), 32'd1);
        check("c_wr_aw", {awaddr[31:4], awlen[3:0]}, {28'h0000_204, 4'd3});
        check("c_wr_awsize", 32'(awsize), 32'd2);
        breq.wvalid = 1'b1;
        breq.wdata  = 32'hD0;
        wready      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("c_wr_no_early_w", {30'd0, wvalid, bresp_c.wready}, 32'd0);
            @(negedge clk);
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        beat = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hD0 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            breq.wvalid = wpat[c];
            breq.wdata  = 32'hD0 + 32'(beat);
            #1;
            check("c_wr_wvalid", 32'(wvalid), 32'(wpat[c]));
            if (wpat[c]) begin
                check("c_wr_wdata", wdata, exp_q.pop_front());
                check("c_wr_wlast", 32'(wlast), 32'(beat == 3));
                check("c_wr_wstrb", 32'(wstrb), 32'hF);
                beat++;
            end
            @(negedge clk);
        end
        breq.wvalid = 1'b0;
        check("c_wr_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        bresp  = RESP_OKAY;
        #1;
        check("c_wr_wdone_not_early", 32'(bresp_c.wdone), 32'd0);
        @(negedge clk);
        bvalid = 1'b0;
        check("c_wr_wdone", {30'd0, bresp_c.wdone, bresp_c.err}, 32'd2);
        @(negedge clk);
        check("c_wr_wdone_once", 32'(bresp_c.wdone), 32'd0);

        // Uncached byte store, SLVERR
        issue_req("u_wr", 1'b1, 1'b1, 32'h4000_0002, 2'd0, 4'b0100);
        check("u_wr_aw", {awaddr, 8'd0} | 40'(awlen), {32'h4000_0002, 8'd0});
        check("u_wr_awsize", 32'(awsize), 32'd0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        breq.wvalid = 1'b1;
        breq.wdata  = 32'h00AB_0000;
        #1;
        check("u_wr_wstrb", 32'(wstrb), 32'h4);
        check("u_wr_wlast", {30'd0, wvalid, wlast}, 32'd3);
        @(negedge clk);
        breq.wvalid = 1'b0;
        bvalid = 1'b1;
        bresp  = 2'b10;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = RESP_OKAY;
        check("u_wr_done_err", {30'd0, bresp_c.wdone, bresp_c.err}, 32'd3);
        @(negedge clk);
        check("u_wr_err_pulse", {30'd0, bresp_c.wdone, bresp_c.err}, 32'd0);

        // Early rlast on beat 2 of a 4-beat burst, then next request
        read_txn("short_rd", 32'h0000_3000, 2'd2, 1'b0, 32'h0000_3000, 8'd3, 3'd2, 2, 32'hB0, 1'b1);
        read_txn("after_short", 32'h0000_0010, 2'd2, 1'b1, 32'h0000_0010, 8'd0, 3'd2, 1, 32'hC0, 1'b0);

        // Reset during beat 2 of a refill
        issue_req("rst_rd", 1'b0, 1'b0, 32'h0000_5000, 2'd2, 4'h0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hE0; rlast = 1'b0;
        @(negedge clk);
        rdata = 32'hE1;
        #1;
        check("rst_mid_rvalid_before", 32'(bresp_c.rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valids", {28'd0, bresp_c.rvalid, rready, arvalid, awvalid}, 32'd0);
        check("rst_mid_state", 32'(fsm_state), 32'(S_IDLE));
        check("rst_mid_ready", 32'(bresp_c.ready), 32'd0);
        rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_txn("fresh_rd", 32'h0000_6004, 2'd2, 1'b0, 32'h0000_6000, 8'd3, 3'd2, 4, 32'hF0, 1'b0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
